ecc_mem_ctrl: RTL and testbench



---
 rtl/ecc_mem_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_ecc_mem_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_mem_ctrl.sv
// SECDED-protected single-port memory controller with background scrubbing.
// Holds the shared Hamming helpers, the correction_detection decoder and the controller top.

package ecc_mem_ctrl_pkg;

  // Hamming check bits: data bit i occupies the i-th non-power-of-two codeword position.
  function automatic logic [5:0] check_bits(input logic [31:0] d);
    logic [5:0] c;
    int unsigned di;
    c  = '0;
    di = 0;
    for (int unsigned p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int unsigned j = 0; j < 6; j++) begin
          if (p[j]) c[j] = c[j] ^ d[di];
        end
        di++;
      end
    end
    return c;
  endfunction

  function automatic logic [6:0] encode(input logic [31:0] d);
    logic [5:0] c;
    c = check_bits(d);
    return {^{d, c}, c};
  endfunction

  function automatic logic [31:0] flip_mask(input logic [5:0] syn);
    logic [31:0] m;
    int unsigned di;
    m  = '0;
    di = 0;
    for (int unsigned p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (syn == p[5:0]) m[di] = 1'b1;
        di++;
      end
    end
    return m;
  endfunction

endpackage

module correction_detection (
  input  logic [31:0] data,
  input  logic [6:0]  parity,
  output logic [31:0] corrected,
  output logic        single_error,
  output logic        double_error
);
  import ecc_mem_ctrl_pkg::*;

  logic [5:0] syn;
  logic       overall;

  always_comb begin
    syn          = check_bits(data) ^ parity[5:0];
    overall      = ^{parity, data};
    single_error = overall;
    // An odd-weight error pointing outside the codeword cannot be a single flip.
    double_error = ((syn != '0) && !overall) || (overall && (syn > 6'd38));
    corrected    = data;
    if (overall) corrected = data ^ flip_mask(syn);
  end
endmodule

module ecc_mem_ctrl #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [38:0]       inject_mask,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_sbe,
  output logic              rsp_dbe,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count,
  output logic [ADDR_W-1:0] last_dbe_addr,
  output logic [ADDR_W-1:0] scrub_addr
);
  import ecc_mem_ctrl_pkg::*;

  localparam int unsigned TW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TW-1:0]     TIMER_LAST = TW'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD, CHK, WB} state_t;

  state_t            state;
  logic [38:0]       mem [DEPTH];
  logic [38:0]       rd_word;
  logic [ADDR_W-1:0] op_addr;
  logic              op_scrub;
  logic              scrub_due;
  logic [TW-1:0]     scrub_timer;

  logic [31:0]       corr_data;
  logic              dec_sbe;
  logic              dec_dbe;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [38:0]       mem_wdata;

  correction_detection u_dec (
    .data         (rd_word[31:0]),
    .parity       (rd_word[38:32]),
    .corrected    (corr_data),
    .single_error (dec_sbe),
    .double_error (dec_dbe)
  );

  // Single write port shared by host writes (IDLE) and corrective writeback (WB).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = {encode(req_wdata), req_wdata} ^ inject_mask;
    if (state == IDLE && req_valid && req_ready && req_we) begin
      mem_we = 1'b1;
    end else if (state == WB) begin
      mem_we    = 1'b1;
      mem_waddr = op_addr;
      mem_wdata = {encode(corr_data), corr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state == RD) rd_word <= mem[op_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_sbe       <= 1'b0;
      rsp_dbe       <= 1'b0;
      sbe_count     <= '0;
      dbe_count     <= '0;
      last_dbe_addr <= '0;
      scrub_addr    <= '0;
      op_addr       <= '0;
      op_scrub      <= 1'b0;
      scrub_due     <= 1'b0;
      scrub_timer   <= '0;
    end else begin
      rsp_valid <= 1'b0;

      if (!scrub_due) begin
        if (scrub_timer == TIMER_LAST) begin
          scrub_due   <= 1'b1;
          scrub_timer <= '0;
        end else begin
          scrub_timer <= scrub_timer + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (!req_we) begin
              op_addr   <= req_addr;
              op_scrub  <= 1'b0;
              state     <= RD;
              req_ready <= 1'b0;
            end else begin
              req_ready <= 1'b1;
            end
          end else if (scrub_due) begin
            op_addr   <= scrub_addr;
            op_scrub  <= 1'b1;
            scrub_due <= 1'b0;
            state     <= RD;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: state <= CHK;
        CHK: begin
          if (!op_scrub) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= corr_data;
            rsp_sbe   <= dec_sbe && !dec_dbe;
            rsp_dbe   <= dec_dbe;
          end
          if (dec_dbe) begin
            if (dbe_count != '1) dbe_count <= dbe_count + 1'b1;
            last_dbe_addr <= op_addr;
            state         <= IDLE;
            req_ready     <= 1'b1;
          end else if (dec_sbe) begin
            if (sbe_count != '1) sbe_count <= sbe_count + 1'b1;
            state <= WB;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
          if (op_scrub) scrub_addr <= (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + 1'b1;
        end
        WB: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed self-checking bench for ecc_mem_ctrl (short scrub interval, 2-bit counters).
module tb_ecc_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [38:0] inject_mask = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_sbe;
  logic        rsp_dbe;
  logic [1:0]  sbe_count;
  logic [1:0]  dbe_count;
  logic [7:0]  last_dbe_addr;
  logic [7:0]  scrub_addr;

  int checks = 0;
  int failures = 0;

  ecc_mem_ctrl #(
    .ADDR_W         (8),
    .DEPTH          (256),
    .SCRUB_INTERVAL (16),
    .CNT_W          (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .inject_mask   (inject_mask),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_sbe       (rsp_sbe),
    .rsp_dbe       (rsp_dbe),
    .sbe_count     (sbe_count),
    .dbe_count     (dbe_count),
    .last_dbe_addr (last_dbe_addr),
    .scrub_addr    (scrub_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] addr, input logic [31:0] data, input logic [38:0] mask);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_ready_timeout addr=%0d got=%b want=1", addr, req_ready);
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; inject_mask = mask;
    @(posedge clk);
    #1 req_valid = 1'b0; inject_mask = '0;
  endtask

  task automatic host_read(input logic [7:0] addr, output logic [31:0] data,
                           output logic sbe, output logic dbe, output logic rdy);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL read_ready_timeout addr=%0d got=%b want=1", addr, req_ready);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_early addr=%0d got=%b want=0", addr, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_latency addr=%0d got=%b want=1", addr, rsp_valid);
    end
    data = rsp_rdata; sbe = rsp_sbe; dbe = rsp_dbe; rdy = req_ready;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({rsp_valid, req_ready, rsp_sbe, rsp_dbe, rsp_rdata, sbe_count, dbe_count, last_dbe_addr, scrub_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {rsp_valid, req_ready, rsp_sbe, rsp_dbe, rsp_rdata, sbe_count, dbe_count, last_dbe_addr, scrub_addr});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic init_memory();
    for (int a = 0; a < 256; a++) host_write(8'(a), 32'(a) * 32'h0101_0101 ^ 32'h5A00_00C3, '0);
  endtask

  task automatic test_basic();
    logic [31:0] d; logic s, b, r;
    logic [38:0] w;
    host_write(8'd5, 32'h1, '0);
    host_read(8'd5, d, s, b, r);
    checks++;
    if ({d, s, b, r} !== {32'h1, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic_read got=%h/%b/%b/%b want=00000001/0/0/1", d, s, b, r);
    end
    w = dut.mem[5];
    checks++;
    if (w[38:32] !== 7'h43) begin
      failures++;
      $display("FAIL basic_parity got=%h want=43", w[38:32]);
    end
  endtask

  task automatic test_single();
    logic [31:0] d; logic s, b, r;
    host_write(8'd3, 32'h0, 39'h1);
    host_read(8'd3, d, s, b, r);
    checks++;
    if ({d, s, b, sbe_count, r} !== {32'h0, 1'b1, 1'b0, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL sbe_read got=%h/%b/%b/%0d/%b want=00000000/1/0/1/0", d, s, b, sbe_count, r);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL sbe_wb_len got=%b want=1", req_ready);
    end
    host_read(8'd3, d, s, b, r);
    checks++;
    if ({d, s, b, sbe_count, r} !== {32'h0, 1'b0, 1'b0, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL sbe_reread got=%h/%b/%b/%0d/%b want=00000000/0/0/1/1", d, s, b, sbe_count, r);
    end
  endtask

  task automatic test_double();
    logic [31:0] d; logic s, b, r;
    host_write(8'd7, 32'h3, 39'h3);
    host_read(8'd7, d, s, b, r);
    checks++;
    if ({s, b, dbe_count, last_dbe_addr, r} !== {1'b0, 1'b1, 2'd1, 8'd7, 1'b1}) begin
      failures++;
      $display("FAIL dbe_read got=%b/%b/%0d/%0d/%b want=0/1/1/7/1", s, b, dbe_count, last_dbe_addr, r);
    end
    host_read(8'd7, d, s, b, r);
    checks++;
    if ({b, dbe_count} !== {1'b1, 2'd2}) begin
      failures++;
      $display("FAIL dbe_reread got=%b/%0d want=1/2", b, dbe_count);
    end
    host_read(8'd7, d, s, b, r);
    host_read(8'd7, d, s, b, r);
    checks++;
    if ({b, dbe_count, sbe_count} !== {1'b1, 2'd3, 2'd1}) begin
      failures++;
      $display("FAIL dbe_saturate got=%b/%0d/%0d want=1/3/1", b, dbe_count, sbe_count);
    end
  endtask

  task automatic test_scrub();
    logic [31:0] d; logic s, b, r;
    int n;
    host_write(8'd0, 32'hA5A5_0F0F, 39'h2_0000);
    n = 0;
    while (sbe_count != 2'd1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ({sbe_count, scrub_addr, rsp_valid} !== {2'd1, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL scrub_fix got=%0d/%0d/%b want=1/1/0 after %0d cycles", sbe_count, scrub_addr, rsp_valid, n);
    end
    host_read(8'd0, d, s, b, r);
    checks++;
    if ({d, s, b, sbe_count} !== {32'hA5A5_0F0F, 1'b0, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL scrub_clean got=%h/%b/%b/%0d want=a5a50f0f/0/0/1", d, s, b, sbe_count);
    end
  endtask

  task automatic test_priority();
    repeat (16) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL prio_accept got=%b want=0", req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_rdata, scrub_addr, req_ready} !== {1'b1, 32'h1, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL prio_host_first got=%b/%h/%0d/%b want=1/00000001/0/1", rsp_valid, rsp_rdata, scrub_addr, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL prio_scrub_start got=%b/%b want=0/0", req_ready, rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({scrub_addr, rsp_valid} !== {8'd1, 1'b0}) begin
      failures++;
      $display("FAIL prio_scrub_done got=%0d/%b want=1/0", scrub_addr, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, req_ready, rsp_sbe, rsp_dbe, rsp_rdata, sbe_count, dbe_count, last_dbe_addr, scrub_addr} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h want=0",
               {rsp_valid, req_ready, rsp_sbe, rsp_dbe, rsp_rdata, sbe_count, dbe_count, last_dbe_addr, scrub_addr});
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_rsp got=%b want=0", rsp_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_release got=%b/%b want=1/0", req_ready, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    init_memory();
    do_reset();
    test_basic();
    test_single();
    test_double();
    do_reset();
    test_scrub();
    do_reset();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
